router_pkt_register: RTL and testbench
======================================

# router_pkt_register

Parametrised packet-datapath register stage for the router: it latches the header, registers payload toward the channel FIFOs and holds one byte while the FIFO is full. It accumulates a selectable check (XOR parity or CRC-8), tracks payload length against the header, and flags errors, including a saturating error counter. It sits between the router FSM (state strobes) and the synchroniser/FIFO bank, and is a drop-in successor for the fixed 8-bit, 3-channel, XOR-only register stage.

## Interface
- DW, 8, data/symbol width (≥4)
- NCH, 3, number of output channels (2..2^(DW-2))
- CHK_MODE, 0, 0 = XOR parity over all header+payload symbols; 1 = CRC-8 (poly 0x07, init 0x00, MSB-first; DW must be 8, otherwise elaboration error)
- ERRCNT_W, 8, width of error counter
- clk  in  1  clock; all logic on rising edge
- resetn  in  1  reset, synchronous, active-low
- pkt_valid  in  1  source packet-valid
- data_in  in  DW  source symbol
- fifo_full  in  1  full flag of selected channel FIFO
- detect_addr, lfd_state, ld_state, laf_state, full_state  in  1 each  router FSM state strobes (one-hot)
- rst_int_reg  in  1  clears low_pkt_valid
- cnt_clr  in  1  clears err_cnt
- data_out  out  DW  symbol to FIFO
- dest_ch  out  AW  latched destination, AW = max(1, clog2(NCH))
- hdr_ok  out  1  combinational: data_in[AW-1:0] < NCH
- parity_done  out  1  check byte captured for current packet
- low_pkt_valid  out  1  pkt_valid dropped during load
- err  out  1  check mismatch
- len_err  out  1  payload count ≠ header length field
- err_cnt  out  ERRCNT_W  saturating count of packets with err or len_err

## Operation
- Header: on detect_addr && pkt_valid && hdr_ok: header, dest_ch, and exp_len = data_in[DW-1:AW] are loaded; check, pay_cnt, packet_parity, parity_done, err and len_err are cleared. If detect_addr is asserted with !hdr_ok, nothing is loaded, but clears still apply.
- data_out priority: lfd_state → header; ld_state && !fifo_full → data_in; laf_state → hold; otherwise hold value.
- Hold register: on ld_state && fifo_full, hold <= data_in and hold_par <= !pkt_valid.
- Check accumulation (one symbol per cycle, chk_next from sub-module):
  - lfd_state → header is folded in.
  - ld_state && pkt_valid && !fifo_full → data_in is folded in, pay_cnt++.
  - laf_state && !hold_par && !parity_done → hold is folded in, pay_cnt++.
- Check capture: on ld_state && !pkt_valid && !fifo_full, packet_parity <= data_in. On laf_state && hold_par && !parity_done, packet_parity <= hold. In both cases parity_done <= 1. parity_done is cleared only by reset or header load.
- low_pkt_valid: the reset/rst_int_reg clear wins; otherwise it is set on ld_state && !pkt_valid and is sticky.
- While parity_done = 1, every cycle:
  - err <= (check != packet_parity)
  - len_err <= (pay_cnt != exp_len)
  - otherwise both are 0.
- err_cnt increments when parity_done && (mismatch || len mismatch) && !err && !len_err, i.e. once per bad packet. It saturates at all-ones. cnt_clr has priority over increment.
- pay_cnt is DW-AW bits wide and saturates; it does not wrap.
- full_state freezes all state (no capture, no check update).

## Timing
- Reset values: data_out 0, dest_ch 0, parity_done 0, low_pkt_valid 0, err 0, len_err 0, err_cnt 0; internal header, hold, check, packet_parity, pay_cnt, exp_len are all 0.
- Reset mid-packet discards everything; the next packet requires detect_addr.
- Every registered output updates one cycle after the qualifying strobe.
- Capture at edge t sets parity_done at t. err, len_err and the err_cnt increment then appear at t+1.
- detect_addr in the same cycle as parity_done clears everything; no error is reported.

## Structure
- Shared package router_pkg holds:
  - CHK_XOR / CHK_CRC8 constants
  - CRC8_POLY = 8'h07
  - function clog2_min1
- Sub-module router_chk_unit: combinational, (CHK_MODE, DW) params, inputs chk_cur and sym, output chk_next (XOR or one-symbol CRC-8 step).
- The top module holds all registers.

## Test plan
- XOR, DW=8, NCH=3: header 0x0D (ch1, len 3), payload 0x11/0x22/0x33, check 0x0D → parity_done=1, err=0, len_err=0, dest_ch=1, err_cnt=0.
- Same packet with check 0x0C → err=1 one cycle after parity_done, err_cnt=1; repeat the packet → err_cnt=2.
- Header 0x0F (addr 3, NCH=3) → hdr_ok=0, dest_ch unchanged, nothing loaded.
- fifo_full during ld on payload 0x22, then laf → data_out=0x22, the check still includes 0x22, err=0. Same with the check byte held → parity_done set in laf.
- Header len 4, only 3 payload bytes → len_err=1, err_cnt=1. Drive err_cnt to 0xFF → it stays 0xFF; cnt_clr → 0.
- CHK_MODE=1: header 0x05, payload 0x01, check = CRC-8 of {0x05,0x01} → err=0; check XOR 0x01 → err=1. Reset mid-payload → all outputs 0.

Source files
------------

// File: rtl/router_pkg.sv
// Shared definitions for the router packet datapath.
// Check-mode selectors, CRC-8 polynomial, and a width helper
// used to size the destination-channel field.
package router_pkg;

  localparam int CHK_XOR  = 0;
  localparam int CHK_CRC8 = 1;

  localparam logic [7:0] CRC8_POLY = 8'h07;

  // Address width for n channels; never less than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/router_chk_unit.sv
// One-symbol check step: XOR parity or MSB-first CRC-8.
// Purely combinational, zero latency.
// No flow control; the caller decides when to register chk_next.
module router_chk_unit
  import router_pkg::*;
#(
  parameter int CHK_MODE = CHK_XOR,
  parameter int DW       = 8
) (
  input  logic [DW-1:0] chk_cur,
  input  logic [DW-1:0] sym,
  output logic [DW-1:0] chk_next
);

  if (CHK_MODE == CHK_CRC8 && DW != 8) begin : g_bad_width
    $error("router_chk_unit: CRC-8 mode requires DW == 8");
  end else if (CHK_MODE == CHK_CRC8) begin : g_crc8
    localparam logic [DW-1:0] POLY = DW'(CRC8_POLY);
    logic [DW-1:0] crc;

    // Fold the symbol into the register, then shift it through bit by bit.
    always_comb begin
      crc = chk_cur ^ sym;
      for (int i = 0; i < DW; i++) begin
        crc = crc[DW-1] ? ((crc << 1) ^ POLY) : (crc << 1);
      end
      chk_next = crc;
    end
  end else begin : g_xor
    assign chk_next = chk_cur ^ sym;
  end

endmodule

// File: rtl/router_pkt_register.sv
// Packet register stage: latches header, feeds payload to the channel FIFOs,
// parks one symbol while the FIFO is full, and checks parity/CRC and length.
// All outputs registered one cycle after the FSM strobe; hdr_ok is combinational.
module router_pkt_register
  import router_pkg::*;
#(
  parameter int DW       = 8,
  parameter int NCH      = 3,
  parameter int CHK_MODE = CHK_XOR,
  parameter int ERRCNT_W = 8,
  localparam int AW      = clog2_min1(NCH)
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                pkt_valid,
  input  logic [DW-1:0]       data_in,
  input  logic                fifo_full,
  input  logic                detect_addr,
  input  logic                lfd_state,
  input  logic                ld_state,
  input  logic                laf_state,
  input  logic                full_state,
  input  logic                rst_int_reg,
  input  logic                cnt_clr,
  output logic [DW-1:0]       data_out,
  output logic [AW-1:0]       dest_ch,
  output logic                hdr_ok,
  output logic                parity_done,
  output logic                low_pkt_valid,
  output logic                err,
  output logic                len_err,
  output logic [ERRCNT_W-1:0] err_cnt
);

  localparam int LW = DW - AW;
  localparam logic [AW:0] NCH_LIM = (AW + 1)'(NCH);

  logic [DW-1:0] header;
  logic [DW-1:0] hold;
  logic          hold_par;
  logic [DW-1:0] chk;
  logic [DW-1:0] chk_next;
  logic [DW-1:0] chk_sym;
  logic [DW-1:0] packet_parity;
  logic [LW-1:0] pay_cnt;
  logic [LW-1:0] exp_len;

  // full_state freezes the stage, so every strobe is qualified by it.
  logic live, s_det, s_lfd, s_ld, s_laf;
  logic fold_ld, fold_laf, fold_en, cnt_en;
  logic cap_ld, cap_laf;
  logic chk_bad, len_bad, cnt_inc;

  assign hdr_ok   = ({1'b0, data_in[AW-1:0]} < NCH_LIM);

  assign live     = !full_state;
  assign s_det    = live && detect_addr;
  assign s_lfd    = live && lfd_state;
  assign s_ld     = live && ld_state;
  assign s_laf    = live && laf_state;

  assign fold_ld  = s_ld && pkt_valid && !fifo_full;
  assign fold_laf = s_laf && !hold_par && !parity_done;
  assign cnt_en   = fold_ld || fold_laf;
  assign fold_en  = s_lfd || cnt_en;

  assign cap_ld   = s_ld && !pkt_valid && !fifo_full;
  assign cap_laf  = s_laf && hold_par && !parity_done;

  assign chk_bad  = (chk != packet_parity);
  assign len_bad  = (pay_cnt != exp_len);
  // Count once per bad packet: only on the cycle before err/len_err rise.
  assign cnt_inc  = live && !s_det && parity_done && (chk_bad || len_bad)
                    && !err && !len_err;

  // Pick which symbol is folded into the check this cycle.
  always_comb begin
    chk_sym = data_in;
    if (s_lfd)         chk_sym = header;
    else if (fold_laf) chk_sym = hold;
  end

  router_chk_unit #(
    .CHK_MODE (CHK_MODE),
    .DW       (DW)
  ) u_chk (
    .chk_cur  (chk),
    .sym      (chk_sym),
    .chk_next (chk_next)
  );

  // Latch header, destination and expected length on a valid address byte.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      header  <= '0;
      dest_ch <= '0;
      exp_len <= '0;
    end else if (s_det && pkt_valid && hdr_ok) begin
      header  <= data_in;
      dest_ch <= data_in[AW-1:0];
      exp_len <= data_in[DW-1:AW];
    end
  end

  // Symbol presented to the FIFO: header, live payload, or the parked byte.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      data_out <= '0;
    end else if (s_lfd) begin
      data_out <= header;
    end else if (s_ld && !fifo_full) begin
      data_out <= data_in;
    end else if (s_laf) begin
      data_out <= hold;
    end
  end

  // Park the symbol that arrived while the FIFO was full; remember if it was the check byte.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      hold     <= '0;
      hold_par <= 1'b0;
    end else if (s_ld && fifo_full) begin
      hold     <= data_in;
      hold_par <= !pkt_valid;
    end
  end

  // Running check and saturating payload count.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      chk     <= '0;
      pay_cnt <= '0;
    end else if (s_det) begin
      chk     <= '0;
      pay_cnt <= '0;
    end else if (fold_en) begin
      chk <= chk_next;
      if (cnt_en && pay_cnt != '1) pay_cnt <= pay_cnt + LW'(1);
    end
  end

  // Capture the trailing check byte, either live or from the hold register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      packet_parity <= '0;
      parity_done   <= 1'b0;
    end else if (s_det) begin
      packet_parity <= '0;
      parity_done   <= 1'b0;
    end else if (cap_ld) begin
      packet_parity <= data_in;
      parity_done   <= 1'b1;
    end else if (cap_laf) begin
      packet_parity <= hold;
      parity_done   <= 1'b1;
    end
  end

  // Sticky flag for pkt_valid dropping during load; FSM clears it explicitly.
  always_ff @(posedge clk) begin
    if (!resetn || rst_int_reg) begin
      low_pkt_valid <= 1'b0;
    end else if (s_ld && !pkt_valid) begin
      low_pkt_valid <= 1'b1;
    end
  end

  // Error flags are re-evaluated every cycle once the check byte is in.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      err     <= 1'b0;
      len_err <= 1'b0;
    end else if (live) begin
      if (!s_det && parity_done) begin
        err     <= chk_bad;
        len_err <= len_bad;
      end else begin
        err     <= 1'b0;
        len_err <= 1'b0;
      end
    end
  end

  // Saturating bad-packet counter; clear beats increment.
  always_ff @(posedge clk) begin
    if (!resetn || cnt_clr) begin
      err_cnt <= '0;
    end else if (cnt_inc && err_cnt != '1) begin
      err_cnt <= err_cnt + ERRCNT_W'(1);
    end
  end

endmodule

// File: tb/tb_router_pkt_register.sv
// Directed bench for router_pkt_register: an XOR instance and a CRC-8 instance
// share one stimulus stream; each phase checks the instance it targets.
module tb_router_pkt_register;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetn, pkt_valid, fifo_full;
  logic       detect_addr, lfd_state, ld_state, laf_state, full_state;
  logic       rst_int_reg, cnt_clr;
  logic [7:0] data_in;

  logic [7:0] x_data_out, c_data_out;
  logic [1:0] x_dest_ch, c_dest_ch;
  logic       x_hdr_ok, c_hdr_ok, x_pdone, c_pdone, x_low, c_low;
  logic       x_err, c_err, x_len_err, c_len_err;
  logic [7:0] x_cnt, c_cnt;

  int total = 0;
  int bad   = 0;

  router_pkt_register #(.DW(8), .NCH(3), .CHK_MODE(0), .ERRCNT_W(8)) u_xor (
    .clk(clk), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .detect_addr(detect_addr), .lfd_state(lfd_state),
    .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
    .rst_int_reg(rst_int_reg), .cnt_clr(cnt_clr), .data_out(x_data_out),
    .dest_ch(x_dest_ch), .hdr_ok(x_hdr_ok), .parity_done(x_pdone),
    .low_pkt_valid(x_low), .err(x_err), .len_err(x_len_err), .err_cnt(x_cnt)
  );

  router_pkt_register #(.DW(8), .NCH(3), .CHK_MODE(1), .ERRCNT_W(8)) u_crc (
    .clk(clk), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .detect_addr(detect_addr), .lfd_state(lfd_state),
    .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
    .rst_int_reg(rst_int_reg), .cnt_clr(cnt_clr), .data_out(c_data_out),
    .dest_ch(c_dest_ch), .hdr_ok(c_hdr_ok), .parity_done(c_pdone),
    .low_pkt_valid(c_low), .err(c_err), .len_err(c_len_err), .err_cnt(c_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle;
    detect_addr = 1'b0; lfd_state = 1'b0; ld_state = 1'b0;
    laf_state = 1'b0; full_state = 1'b0; fifo_full = 1'b0;
    rst_int_reg = 1'b0; cnt_clr = 1'b0;
  endtask

  // Header, lfd, n payload bytes, then the check byte with pkt_valid low.
  task automatic send_pkt(input logic [7:0] hdr, input logic [7:0] p0,
                          input logic [7:0] p1, input logic [7:0] p2,
                          input int n, input logic [7:0] cb);
    set_idle; detect_addr = 1'b1; pkt_valid = 1'b1; data_in = hdr; tick;
    set_idle; lfd_state = 1'b1; tick;
    for (int i = 0; i < n; i++) begin
      set_idle; ld_state = 1'b1; pkt_valid = 1'b1;
      data_in = (i == 0) ? p0 : (i == 1) ? p1 : p2;
      tick;
    end
    set_idle; ld_state = 1'b1; pkt_valid = 1'b0; data_in = cb; tick;
    set_idle;
  endtask

  task automatic pulse_rst_int;
    set_idle; rst_int_reg = 1'b1; tick; set_idle;
  endtask

  task automatic pulse_cnt_clr;
    set_idle; cnt_clr = 1'b1; tick; set_idle;
  endtask

  initial begin
    resetn = 1'b0; pkt_valid = 1'b0; data_in = 8'h00; set_idle;
    tick; tick;
    check_eq("rst_data_out", x_data_out, 0);
    check_eq("rst_dest_ch", x_dest_ch, 0);
    check_eq("rst_pdone", x_pdone, 0);
    check_eq("rst_low", x_low, 0);
    check_eq("rst_err", {x_err, x_len_err}, 0);
    check_eq("rst_cnt", x_cnt, 0);
    resetn = 1'b1;
    tick;

    // Good XOR packet: 0x0D ^ 0x11 ^ 0x22 ^ 0x33 = 0x0D.
    send_pkt(8'h0D, 8'h11, 8'h22, 8'h33, 3, 8'h0D);
    check_eq("good_pdone", x_pdone, 1);
    check_eq("good_data_out", x_data_out, 8'h0D);
    tick;
    check_eq("good_err", x_err, 0);
    check_eq("good_len_err", x_len_err, 0);
    check_eq("good_dest", x_dest_ch, 1);
    check_eq("good_cnt", x_cnt, 0);
    check_eq("good_low", x_low, 1);
    pulse_rst_int;
    check_eq("rst_int_low", x_low, 0);

    // Wrong check byte: err rises one cycle after parity_done, counted once.
    send_pkt(8'h0D, 8'h11, 8'h22, 8'h33, 3, 8'h0C);
    check_eq("bad_pdone", x_pdone, 1);
    check_eq("bad_err_early", x_err, 0);
    tick;
    check_eq("bad_err", x_err, 1);
    check_eq("bad_cnt1", x_cnt, 1);
    tick;
    check_eq("bad_cnt_once", x_cnt, 1);
    send_pkt(8'h0D, 8'h11, 8'h22, 8'h33, 3, 8'h0C);
    tick;
    check_eq("bad_cnt2", x_cnt, 2);

    // Address 3 with NCH=3: rejected, but clears still happen.
    set_idle; detect_addr = 1'b1; pkt_valid = 1'b1; data_in = 8'h0F;
    #1;
    check_eq("hdr_ok_low", x_hdr_ok, 0);
    tick;
    check_eq("badhdr_dest", x_dest_ch, 1);
    check_eq("badhdr_pdone", x_pdone, 0);
    check_eq("badhdr_err", x_err, 0);
    set_idle; lfd_state = 1'b1; tick;
    check_eq("badhdr_header_kept", x_data_out, 8'h0D);
    set_idle; data_in = 8'h0E; #1;
    check_eq("hdr_ok_high", x_hdr_ok, 1);

    // FIFO full on payload 0x22, parked, then released in laf.
    set_idle; detect_addr = 1'b1; pkt_valid = 1'b1; data_in = 8'h0D; tick;
    set_idle; lfd_state = 1'b1; tick;
    set_idle; ld_state = 1'b1; data_in = 8'h11; tick;
    set_idle; ld_state = 1'b1; fifo_full = 1'b1; data_in = 8'h22; tick;
    check_eq("ff_out_held", x_data_out, 8'h11);
    set_idle; full_state = 1'b1; fifo_full = 1'b1; data_in = 8'hAA; tick;
    check_eq("ff_frozen", x_data_out, 8'h11);
    set_idle; laf_state = 1'b1; tick;
    check_eq("ff_laf_out", x_data_out, 8'h22);
    set_idle; ld_state = 1'b1; data_in = 8'h33; tick;
    set_idle; ld_state = 1'b1; pkt_valid = 1'b0; data_in = 8'h0D; tick;
    check_eq("ff_pdone", x_pdone, 1);
    set_idle; tick;
    check_eq("ff_err", x_err, 0);
    check_eq("ff_len_err", x_len_err, 0);

    // FIFO full on the check byte: captured from hold during laf.
    pulse_rst_int;
    set_idle; detect_addr = 1'b1; pkt_valid = 1'b1; data_in = 8'h0D; tick;
    set_idle; lfd_state = 1'b1; tick;
    set_idle; ld_state = 1'b1; data_in = 8'h11; tick;
    set_idle; ld_state = 1'b1; data_in = 8'h22; tick;
    set_idle; ld_state = 1'b1; data_in = 8'h33; tick;
    set_idle; ld_state = 1'b1; pkt_valid = 1'b0; fifo_full = 1'b1; data_in = 8'h0D; tick;
    check_eq("ffc_no_pdone", x_pdone, 0);
    check_eq("ffc_low", x_low, 1);
    set_idle; full_state = 1'b1; fifo_full = 1'b1; tick;
    set_idle; laf_state = 1'b1; tick;
    check_eq("ffc_pdone", x_pdone, 1);
    check_eq("ffc_out", x_data_out, 8'h0D);
    set_idle; tick;
    check_eq("ffc_err", x_err, 0);
    check_eq("ffc_len_err", x_len_err, 0);

    // Header length 4, three payload bytes; check byte itself is right.
    pulse_cnt_clr;
    check_eq("clr_cnt", x_cnt, 0);
    send_pkt(8'h11, 8'h11, 8'h22, 8'h33, 3, 8'h11);
    tick;
    check_eq("len_len_err", x_len_err, 1);
    check_eq("len_err_flag", x_err, 0);
    check_eq("len_cnt", x_cnt, 1);

    // Saturation at 0xFF.
    for (int i = 0; i < 254; i++) begin
      send_pkt(8'h11, 8'h11, 8'h22, 8'h33, 3, 8'h11);
      tick;
    end
    check_eq("sat_reach", x_cnt, 8'hFF);
    send_pkt(8'h11, 8'h11, 8'h22, 8'h33, 3, 8'h11);
    tick;
    check_eq("sat_hold", x_cnt, 8'hFF);
    pulse_cnt_clr;
    check_eq("sat_clr", x_cnt, 0);

    // CRC-8 of {0x05, 0x01} is 0x46.
    send_pkt(8'h05, 8'h01, 8'h00, 8'h00, 1, 8'h46);
    check_eq("crc_pdone", c_pdone, 1);
    tick;
    check_eq("crc_err_ok", c_err, 0);
    check_eq("crc_len_ok", c_len_err, 0);
    check_eq("crc_dest", c_dest_ch, 1);
    check_eq("xor_sees_crc_bad", x_err, 1);
    send_pkt(8'h05, 8'h01, 8'h00, 8'h00, 1, 8'h47);
    tick;
    check_eq("crc_err_bad", c_err, 1);

    // Reset in the middle of a payload.
    set_idle; detect_addr = 1'b1; pkt_valid = 1'b1; data_in = 8'h05; tick;
    set_idle; lfd_state = 1'b1; tick;
    set_idle; ld_state = 1'b1; data_in = 8'h01; tick;
    set_idle; resetn = 1'b0; tick;
    check_eq("mid_rst_data_out", c_data_out, 0);
    check_eq("mid_rst_dest", c_dest_ch, 0);
    check_eq("mid_rst_pdone", c_pdone, 0);
    check_eq("mid_rst_low", c_low, 0);
    check_eq("mid_rst_err", {c_err, c_len_err}, 0);
    check_eq("mid_rst_cnt", c_cnt, 0);
    resetn = 1'b1;
    tick;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
